// File: rtl/column_frame_rx.sv
// Board-to-board move link receiver: samples the peer serial clock/data pair, deserializes
// 10-bit frames (start, D[6:0] MSB first, flag, even parity) and validates one-hot moves.
module column_frame_rx #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_in,
  input  logic       bit_in,
  output logic [6:0] column_select,
  output logic [6:0] constant_col_sel,
  output logic       three_in,
  output logic       frame_valid,
  output logic       frame_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    FLAG   = 2'd2,
    PARITY = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             s1_clk;
  logic             s2_clk;
  logic             c_prev;
  logic             s1_bit;
  logic             s2_bit;
  logic             rise;
  state_t           state;
  logic [2:0]       bit_cnt;
  logic [6:0]       data;
  logic             flag;
  logic [CNT_W-1:0] tmo_cnt;
  logic             timeout;
  logic             parity_ok;
  logic             one_hot;

  // Sync stages reset high so a line parked high across reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_clk <= 1'b1;
      s2_clk <= 1'b1;
      c_prev <= 1'b1;
      s1_bit <= 1'b1;
      s2_bit <= 1'b1;
    end else begin
      s1_clk <= clk_in;
      s2_clk <= s1_clk;
      c_prev <= s2_clk;
      s1_bit <= bit_in;
      s2_bit <= s1_bit;
    end
  end

  assign rise = s2_clk & ~c_prev;

  // A rise landing on the expiry cycle keeps the frame alive.
  assign timeout   = (state != IDLE) && !rise && (tmo_cnt == TMO_LAST);
  assign parity_ok = ~(^{data, flag, s2_bit});
  assign one_hot   = (data != 7'd0) && ((data & (data - 7'd1)) == 7'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      bit_cnt          <= 3'd0;
      data             <= 7'd0;
      flag             <= 1'b0;
      tmo_cnt          <= '0;
      column_select    <= 7'd0;
      constant_col_sel <= 7'd0;
      three_in         <= 1'b0;
      frame_valid      <= 1'b0;
      frame_error      <= 1'b0;
    end else begin
      column_select <= 7'd0;
      three_in      <= 1'b0;
      frame_valid   <= 1'b0;
      frame_error   <= 1'b0;

      if (state == IDLE || rise || timeout) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end

      if (timeout) begin
        frame_error <= 1'b1;
        state       <= IDLE;
        bit_cnt     <= 3'd0;
        data        <= 7'd0;
        flag        <= 1'b0;
      end else if (rise) begin
        case (state)
          IDLE: begin
            if (s2_bit) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
              data    <= 7'd0;
            end
          end
          DATA: begin
            data <= {data[5:0], s2_bit};
            if (bit_cnt == 3'd6) begin
              state <= FLAG;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          FLAG: begin
            flag  <= s2_bit;
            state <= PARITY;
          end
          PARITY: begin
            state <= IDLE;
            if (parity_ok && one_hot) begin
              column_select    <= data;
              constant_col_sel <= data;
              three_in         <= flag;
              frame_valid      <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_column_frame_rx.sv
// Bench for column_frame_rx: frame-level reference model fed by the serial driver,
// compared against the DUT on every cycle, plus directed literal checks.
module tb_column_frame_rx;

  localparam int TMO = 4096;

  logic       clk;
  logic       reset;
  logic       clk_in;
  logic       bit_in;
  logic [6:0] column_select;
  logic [6:0] constant_col_sel;
  logic       three_in;
  logic       frame_valid;
  logic       frame_error;

  column_frame_rx #(.TIMEOUT_CYCLES(TMO), .CNT_W(13)) dut (
    .clk              (clk),
    .reset            (reset),
    .clk_in           (clk_in),
    .bit_in           (bit_in),
    .column_select    (column_select),
    .constant_col_sel (constant_col_sel),
    .three_in         (three_in),
    .frame_valid      (frame_valid),
    .frame_error      (frame_error)
  );

  typedef struct packed {
    logic       acc;
    logic [6:0] col;
    logic       flag;
  } ev_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic rst_seen = 1'b1;

  // Model state: bits of the frame in progress, scheduled outcomes keyed by visible cycle.
  bit   fq[$];
  int   last_rise = 0;
  ev_t  exp_ev[int];
  bit   tmo_ev[int];
  logic [6:0] model_hold = 7'd0;

  int         n_valid = 0;
  int         n_err   = 0;
  int         last_err_cyc = -1;
  logic [6:0] last_col = 7'd0;
  logic       last_three = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // A rise driven at cycle c becomes visible in the outputs at cycle c+3.
  function automatic void model_rise(input int c, input bit b);
    if (fq.size() > 0) begin
      if (c - last_rise > TMO) fq.delete();
      else tmo_ev.delete(last_rise + 3 + TMO);
    end
    last_rise = c;
    if (fq.size() == 0 && !b) return;
    fq.push_back(b);
    if (fq.size() == 10) begin
      int   od;
      ev_t  e;
      od = 0;
      e.col = 7'd0;
      for (int i = 1; i <= 7; i++) begin
        od += int'(fq[i]);
        e.col[7-i] = fq[i];
      end
      e.flag = fq[8];
      e.acc  = ((od + int'(fq[8]) + int'(fq[9])) % 2 == 0) && (od == 1);
      exp_ev[c + 3] = e;
      fq.delete();
    end else begin
      tmo_ev[c + 3 + TMO] = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    logic [6:0] ecol;
    logic       evld, ethree, eerr;
    ecol = 7'd0; evld = 1'b0; ethree = 1'b0; eerr = 1'b0;
    if (cyc > 0) begin
      if (rst_seen) begin
        model_hold = 7'd0;
      end else begin
        if (exp_ev.exists(cyc)) begin
          if (exp_ev[cyc].acc) begin
            evld = 1'b1; ecol = exp_ev[cyc].col; ethree = exp_ev[cyc].flag;
            model_hold = exp_ev[cyc].col;
          end else begin
            eerr = 1'b1;
          end
        end
        if (tmo_ev.exists(cyc)) eerr = 1'b1;
      end
      check("column_select", 32'(column_select), 32'(ecol));
      check("constant_col_sel", 32'(constant_col_sel), 32'(model_hold));
      check("three_in", 32'(three_in), 32'(ethree));
      check("frame_valid", 32'(frame_valid), 32'(evld));
      check("frame_error", 32'(frame_error), 32'(eerr));
      if (frame_valid === 1'b1) begin
        n_valid++; last_col = column_select; last_three = three_in;
      end
      if (frame_error === 1'b1) begin
        n_err++; last_err_cyc = cyc;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input bit b, input int lo, input int hi);
    bit_in = b;
    wait_cyc(lo);
    clk_in = 1'b1;
    model_rise(cyc, b);
    wait_cyc(hi);
    clk_in = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] d, input bit f, input bit p, input int lo, input int hi);
    send_bit(1'b1, lo, hi);
    for (int i = 6; i >= 0; i--) send_bit(d[i], lo, hi);
    send_bit(f, lo, hi);
    send_bit(p, lo, hi);
  endtask

  task automatic do_reset(input int n);
    int keys[$];
    reset = 1'b1;
    foreach (exp_ev[k]) if (k > cyc) keys.push_back(k);
    foreach (keys[i]) exp_ev.delete(keys[i]);
    keys.delete();
    foreach (tmo_ev[k]) if (k > cyc) keys.push_back(k);
    foreach (keys[i]) tmo_ev.delete(keys[i]);
    fq.delete();
    wait_cyc(n);
    reset = 1'b0;
  endtask

  initial begin
    int v0, e0, ntrunc;
    reset = 1'b1; clk_in = 1'b0; bit_in = 1'b0;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(3);
    check("rst_const", 32'(constant_col_sel), 32'd0);
    check("rst_valid", 32'(frame_valid), 32'd0);

    // 1: column 3, no flag, 64-cycle serial period
    v0 = n_valid;
    send_frame(7'b0001000, 1'b0, 1'b1, 32, 32);
    wait_cyc(10);
    check("t1_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("t1_col", 32'(last_col), 32'b0001000);
    check("t1_three", 32'(last_three), 32'd0);
    check("t1_hold", 32'(constant_col_sel), 32'b0001000);

    // 2: column 6 with turn-complete flag
    send_frame(7'b1000000, 1'b1, 1'b0, 5, 5);
    wait_cyc(10);
    check("t2_col", 32'(last_col), 32'b1000000);
    check("t2_three", 32'(last_three), 32'd1);

    // 3: bad parity
    v0 = n_valid; e0 = n_err;
    send_frame(7'b0001000, 1'b0, 1'b0, 4, 4);
    wait_cyc(10);
    check("t3_err_cnt", 32'(n_err - e0), 32'd1);
    check("t3_hold", 32'(constant_col_sel), 32'b1000000);

    // 4: even parity but two bits set
    send_frame(7'b0011000, 1'b0, 1'b0, 4, 4);
    wait_cyc(10);
    check("t4_err_cnt", 32'(n_err - e0), 32'd2);
    check("t4_valid_cnt", 32'(n_valid - v0), 32'd0);

    // 5: stall mid-frame, then recover
    e0 = n_err;
    send_bit(1'b1, 4, 4);
    send_bit(1'b0, 4, 4);
    send_bit(1'b1, 4, 4);
    send_bit(1'b0, 4, 4);
    v0 = last_rise;
    wait_cyc(5000);
    check("t5_err_cnt", 32'(n_err - e0), 32'd1);
    check("t5_timeout_at", 32'(last_err_cyc), 32'(v0 + 3 + 4096));
    v0 = n_valid;
    send_frame(7'b0000001, 1'b0, 1'b1, 4, 4);
    wait_cyc(10);
    check("t5_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("t5_hold", 32'(constant_col_sel), 32'b0000001);

    // Gap of exactly the limit survives; one cycle more aborts.
    e0 = n_err; v0 = n_valid;
    send_bit(1'b1, 4, 3);
    send_bit(1'b0, 4093, 4);
    for (int i = 5; i >= 0; i--) send_bit(i == 1, 4, 4);
    send_bit(1'b0, 4, 4);
    send_bit(1'b1, 4, 4);
    wait_cyc(10);
    check("edge_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("edge_err_cnt", 32'(n_err - e0), 32'd0);
    send_bit(1'b1, 4, 3);
    send_bit(1'b0, 4094, 4);
    wait_cyc(10);
    check("over_err_cnt", 32'(n_err - e0), 32'd1);

    // 6: reset after 5 bits with clk_in high across release, then back-to-back frames
    v0 = n_valid; e0 = n_err;
    send_bit(1'b1, 4, 4);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 4, 4);
    bit_in = 1'b0;
    wait_cyc(4);
    clk_in = 1'b1;
    do_reset(8);
    wait_cyc(6);
    clk_in = 1'b0;
    wait_cyc(4);
    check("t6_no_out", 32'(n_valid - v0 + n_err - e0), 32'd0);
    check("t6_rst_hold", 32'(constant_col_sel), 32'd0);
    send_frame(7'b0000100, 1'b0, 1'b1, 3, 3);
    send_frame(7'b0010000, 1'b0, 1'b1, 3, 3);
    wait_cyc(10);
    check("t6_valid_cnt", 32'(n_valid - v0), 32'd2);
    check("t6_hold", 32'(constant_col_sel), 32'b0010000);

    // Randomized traffic
    ntrunc = 0;
    for (int k = 0; k < 60; k++) begin
      logic [6:0] d;
      bit f, p;
      int lo, hi, mode;
      mode = $urandom_range(0, 9);
      if (mode < 6) d = 7'(1 << $urandom_range(0, 6));
      else d = 7'($urandom_range(0, 127));
      f  = 1'($urandom_range(0, 1));
      p  = ^{d, f};
      if ($urandom_range(0, 4) == 0) p = ~p;
      lo = $urandom_range(3, 12);
      hi = $urandom_range(3, 12);
      if (mode == 9 && ntrunc < 2) begin
        ntrunc++;
        send_bit(1'b1, lo, hi);
        for (int i = 0; i < int'($urandom_range(0, 8)); i++) send_bit(1'($urandom_range(0, 1)), lo, hi);
        wait_cyc(TMO + 50);
      end else begin
        send_frame(d, f, p, lo, hi);
      end
      if ($urandom_range(0, 1) == 1) begin
        bit_in = 1'($urandom_range(0, 1));
        wait_cyc($urandom_range(0, 30));
      end
    end
    wait_cyc(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
